// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle for the 4-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       busy;
   logic       preempt;

   modport master (output req, input gnt, gnt_idx, busy, preempt);
   modport slave  (input req, output gnt, gnt_idx, busy, preempt);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// bounded hold time (MAX_HOLD) and a one-cycle preemption pulse.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic           clock,
   input  logic           reset,
   rr_arbiter_4_if.slave  arb
);

   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("rr_arbiter_4: MAX_HOLD must be >= 1");
   end
   if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
      $error("rr_arbiter_4: CNT_W too narrow for MAX_HOLD");
   end

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pre_q, pre_d;
   logic [3:0]       others;
   logic [1:0]       pick_idx;

   // First set bit scanning last+1, last+2, ... ; k=4 wraps back onto last itself.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
      logic [1:0] pick;
      logic [1:0] cand;
      logic       found;
      pick  = l;
      found = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = l + 2'(k);
         if (!found && r[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Current owner is masked out, so a preempted owner cannot win its own switch.
   always_comb begin
      others   = arb.req & ~gnt_q;
      pick_idx = rr_pick(others, last_q);
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      pre_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|arb.req) begin
               state_d = GRANT;
               idx_d   = pick_idx;
               gnt_d   = 4'b0001 << pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!arb.req[idx_q]) begin
               if (|others) begin
                  idx_d  = pick_idx;
                  gnt_d  = 4'b0001 << pick_idx;
                  last_d = pick_idx;
                  cnt_d  = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end else if (cnt_q != HOLD_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (|others) begin
               idx_d  = pick_idx;
               gnt_d  = 4'b0001 << pick_idx;
               last_d = pick_idx;
               cnt_d  = '0;
               pre_d  = 1'b1;
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
      end
   end

   assign arb.gnt     = gnt_q;
   assign arb.gnt_idx = idx_q;
   assign arb.busy    = |gnt_q;
   assign arb.preempt = pre_q;

endmodule
